// File: rtl/spi_master_seq_if.sv
// Frame handshake bundle between the register block and the SPI master sequencer.
interface spi_master_seq_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_last;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_master_seq.sv
// SPI master transfer sequencer: divided SCLK, SS lead/lag timing, MSB-first shift,
// optional chaining of frames under one slave select.
module spi_master_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned NUM_SS     = 2,
  localparam int unsigned SelW      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [SelW-1:0]      ss_sel,
  spi_master_seq_if.slave      bus,
  output logic                 busy,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic [NUM_SS-1:0]    ss_n
);

  localparam int unsigned EcW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EcW-1:0] EdgeLast = EcW'(2 * DATA_WIDTH - 1);
  localparam logic [EcW-1:0] EdgeDone = EcW'(2 * DATA_WIDTH);

  typedef enum logic [2:0] {StIdle, StLead, StShift, StNext, StLag, StGap} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [EcW-1:0]        edge_cnt_q, edge_cnt_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0]  clk_div_q, clk_div_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic                  last_q, last_d;
  logic                  sclk_q, sclk_d;
  logic [NUM_SS-1:0]     ss_n_q, ss_n_d;

  logic tick;
  logic tx_ready;
  logic rx_valid;
  logic sample;
  logic ss_active;

  assign tick = (div_cnt_q == clk_div_q);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
    edge_cnt_d = edge_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    clk_div_d  = clk_div_q;
    sel_d      = sel_q;
    last_d     = last_q;
    sclk_d     = sclk_q;
    tx_ready   = 1'b0;
    rx_valid   = 1'b0;
    sample     = 1'b0;

    case (state_q)
      StIdle: begin
        tx_ready  = 1'b1;
        sclk_d    = cpol;
        div_cnt_d = '0;
        if (bus.tx_valid) begin
          state_d    = StLead;
          tx_sh_d    = bus.tx_data;
          last_d     = bus.tx_last;
          cpol_d     = cpol;
          cpha_d     = cpha;
          clk_div_d  = clk_div;
          sel_d      = ss_sel;
          edge_cnt_d = '0;
          rx_sh_d    = '0;
        end
      end
      StLead: begin
        if (tick) state_d = StShift;
      end
      StShift: begin
        if (edge_cnt_q == EdgeDone) begin
          // One settle cycle after the final edge; rx_data_q already holds the frame.
          rx_valid = 1'b1;
          state_d  = last_q ? StLag : StNext;
        end else if (tick) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + EcW'(1);
          // Even edge is leading; cpha selects whether leading or trailing samples.
          sample     = ~edge_cnt_q[0] ^ cpha_q;
          if (sample) begin
            rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso};
          end else if (edge_cnt_q != '0 && edge_cnt_q != EdgeLast) begin
            tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (edge_cnt_q == EdgeLast) rx_data_d = rx_sh_d;
        end
      end
      StNext: begin
        tx_ready  = 1'b1;
        sclk_d    = cpol_q;
        div_cnt_d = '0;
        if (bus.tx_valid) begin
          state_d    = StLead;
          tx_sh_d    = bus.tx_data;
          last_d     = bus.tx_last;
          edge_cnt_d = '0;
          rx_sh_d    = '0;
        end
      end
      StLag: begin
        if (tick) state_d = StGap;
      end
      StGap: begin
        if (tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) div_cnt_d = '0;

    // Select decoded from next state so SS moves on the same edge as the FSM.
    ss_active = (state_d == StLead) || (state_d == StShift) ||
                (state_d == StNext) || (state_d == StLag);
    ss_n_d = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (ss_active && sel_d == SelW'(i)) ss_n_d[i] = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= StIdle;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      clk_div_q  <= '0;
      sel_q      <= '0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      clk_div_q  <= clk_div_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
    end
  end

  assign bus.tx_ready = tx_ready;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data  = rx_data_q;
  assign busy         = (state_q != StIdle);
  assign sclk         = sclk_q;
  assign mosi         = tx_sh_q[DATA_WIDTH-1];
  assign ss_n         = ss_n_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// Bench for spi_master_seq: directed frames, behavioural SPI slave, scoreboard monitor.
module tb_spi_master_seq;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] clk_div = 8'd1;
  logic       ss_sel = 1'b0;
  logic       busy, sclk, mosi, miso;
  logic [1:0] ss_n;

  spi_master_seq_if #(.DATA_WIDTH(8)) bus ();

  spi_master_seq #(
    .DATA_WIDTH(8),
    .DIV_WIDTH (8),
    .NUM_SS    (2)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .cpol   (cpol),
    .cpha   (cpha),
    .clk_div(clk_div),
    .ss_sel (ss_sel),
    .bus    (bus),
    .busy   (busy),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .ss_n   (ss_n)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame context captured from the stimulus at accept time
  logic       f_cpol = 1'b0, f_cpha = 1'b0, f_sel = 1'b0;
  int         f_cd = 0;
  logic [7:0] f_slv = 8'h00;
  int         acc_cyc = 0, tog_cnt = 0, last_tog = 0, hi_cnt = 0, bad_cnt = 0;
  logic       sclk_prev;
  logic       acc_tog = 1'b0;
  logic [1:0] sel_mask, exp_ss;
  logic [7:0] slv_cap = 8'h00;

  always @(negedge pclk) begin
    if (preset) begin
      sb_q.delete();
    end else begin
      if (bus.tx_valid && bus.tx_ready) begin
        if (!busy) begin
          f_cpol  = cpol;
          f_cpha  = cpha;
          f_cd    = int'(clk_div);
          f_sel   = ss_sel;
          hi_cnt  = 0;
          bad_cnt = 0;
        end
        acc_cyc = cyc;
        tog_cnt = 0;
        f_slv   = (sb_q.size() > 0) ? sb_q[$].slv : 8'h00;
        acc_tog = ~acc_tog;
      end
      sel_mask = 2'b01 << f_sel;
      exp_ss   = ~sel_mask;
      if (busy) begin
        if (ss_n == 2'b11) hi_cnt++;
        else if (ss_n != exp_ss) bad_cnt++;
        if (sclk !== sclk_prev) begin
          if (tog_cnt > 0) chk("sclk_half_period", cyc - last_tog, f_cd + 1);
          tog_cnt++;
          last_tog = cyc;
        end
      end
      if (bus.rx_valid) begin
        if (sb_q.size() == 0) begin
          chk("rx_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("rx_data", bus.rx_data, e.slv);
          chk("slave_got_mosi", slv_cap, e.tx);
          chk("frame_len", cyc - acc_cyc, 1 + 17 * (f_cd + 1));
          chk("sclk_edges", tog_cnt, 16);
          chk("rx_valid_vs_ready", bus.tx_ready, 0);
          chk("ss_at_rx", ss_n, exp_ss);
        end
      end
    end
    sclk_prev = sclk;
  end

  // Behavioural SPI slave: shifts its word out MSB first, captures mosi
  int         s_idx = 7;
  logic [7:0] s_word = 8'h00;
  logic       s_seen = 1'b0;
  logic       miso_r = 1'b0;
  assign miso = miso_r;

  always @(sclk or acc_tog) begin
    if (acc_tog != s_seen) begin
      s_seen  = acc_tog;
      s_word  = f_slv;
      s_idx   = 7;
      slv_cap = 8'h00;
      miso_r  = f_cpha ? 1'b0 : f_slv[7];
    end else if (busy === 1'b1 && !preset) begin
      if (sclk !== f_cpol) begin
        if (!f_cpha) slv_cap = {slv_cap[6:0], mosi};
        else if (s_idx >= 0) begin
          miso_r = s_word[s_idx];
          s_idx--;
        end
      end else begin
        if (!f_cpha) begin
          s_idx--;
          if (s_idx >= 0) miso_r = s_word[s_idx];
        end else slv_cap = {slv_cap[6:0], mosi};
      end
    end
  end

  task automatic align();
    @(posedge pclk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] slv);
    exp_t x;
    int   n;
    x.tx  = d;
    x.slv = slv;
    sb_q.push_back(x);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = last;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!bus.tx_ready && n < 500);
    chk("accept_ready", bus.tx_ready, 1);
    align();
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    chk("idle_reached", busy, 0);
    chk("ss_gap_cycles", hi_cnt, f_cd + 1);
    chk("ss_glitch", bad_cnt, 0);
    align();
    @(negedge pclk);
    chk("sclk_idle", sclk, cpol);
    chk("ss_idle", ss_n, 2'b11);
    chk("sb_drained", sb_q.size(), 0);
    align();
  endtask

  logic [1:0] modes [3];
  int         seen_rx;

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("rst_ss_n", ss_n, 2'b11);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_busy", busy, 0);
    align();

    // T1: mode 0, half-period 2
    send(8'hA5, 1'b1, 8'hA5);
    wait_idle();

    // T2: remaining modes, {cpol,cpha}
    modes[0] = 2'b01;
    modes[1] = 2'b10;
    modes[2] = 2'b11;
    for (int m = 0; m < 3; m++) begin
      {cpol, cpha} = modes[m];
      align();
      send(8'h3C, 1'b1, 8'h3C);
      wait_idle();
    end
    send(8'h7E, 1'b1, 8'h81);
    wait_idle();

    // T3: chained frames on slave 1 with a gap between them
    cpol = 1'b0;
    cpha = 1'b0;
    ss_sel = 1'b1;
    align();
    send(8'h12, 1'b0, 8'h12);
    begin
      int n;
      n = 0;
      do begin
        @(negedge pclk);
        n++;
      end while (!bus.tx_ready && n < 500);
      chk("chain_next_ready", bus.tx_ready, 1);
      chk("chain_ss_held", ss_n, 2'b01);
      for (int g = 0; g < 4; g++) begin
        @(negedge pclk);
        chk("chain_gap_ready", bus.tx_ready, 1);
      end
      align();
    end
    send(8'h34, 1'b1, 8'h34);
    wait_idle();

    // T4: fastest SCLK, miso held high
    ss_sel  = 1'b0;
    clk_div = 8'd0;
    align();
    send(8'h69, 1'b1, 8'hFF);
    wait_idle();

    // T5: reset lands on SHIFT edge 7
    clk_div = 8'd1;
    align();
    send(8'h77, 1'b1, 8'h77);
    repeat (17) @(posedge pclk);
    #1 preset = 1'b1;
    align();
    preset = 1'b0;
    @(negedge pclk);
    chk("abort_ss_n", ss_n, 2'b11);
    chk("abort_sclk", sclk, 0);
    chk("abort_tx_ready", bus.tx_ready, 1);
    chk("abort_busy", busy, 0);
    seen_rx = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (bus.rx_valid) seen_rx++;
    end
    chk("abort_no_rx", seen_rx, 0);
    align();
    send(8'h5A, 1'b1, 8'h5A);
    wait_idle();

    // T6: config churn while busy must not disturb the frame
    cpol    = 1'b0;
    cpha    = 1'b1;
    clk_div = 8'd2;
    ss_sel  = 1'b0;
    align();
    send(8'hC6, 1'b1, 8'h5B);
    repeat (10) @(posedge pclk);
    #1;
    cpol    = 1'b1;
    cpha    = 1'b0;
    clk_div = 8'd0;
    ss_sel  = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
